rggen_bit_field_w01c_event: RTL and testbench

Event/status bit field, successor to the plain W0C/W1C/WC field. Adds per-bit edge-or-level event capture, a registered masked interrupt request and an optional sticky overflow flag, all cleared by a single software write. Sits behind `rggen_bit_field_if` inside a generated register, with hardware event sources driving `i_set`.

---
 rtl/rggen_bit_field_w01c_event_if.sv | 39 +++
 rtl/rggen_bit_field_w01c_event.sv | 107 ++++++++++
 tb/tb_rggen_bit_field_w01c_event.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_bit_field_w01c_event_if.sv
// rggen_bit_field_if
//   Register-access bundle between a generated register and one of its bit
//   fields.
//   Parameter:
//     WIDTH : width of the field's data path.
//   Signals:
//     valid      : an access to the register is active this cycle.
//     write_data : data written by software.
//     write_mask : per-bit write enable; all zero means no write.
//     read_data  : data the field returns to the register read mux.
//     value      : current raw contents of the field.
//   Modports:
//     bit_field  : the bit-field side (takes the access, returns data).
//     register   : the register side (issues the access).
interface rggen_bit_field_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport bit_field (
    input  valid,
    input  write_data,
    input  write_mask,
    output read_data,
    output value
  );

  modport register (
    output valid,
    output write_data,
    output write_mask,
    input  read_data,
    input  value
  );
endinterface

// File: rtl/rggen_bit_field_w01c_event.sv
// rggen_bit_field_w01c_event
//   Event/status bit field. Each bit captures a hardware event (edge or
//   level, chosen per bit), stays set until software clears it, and feeds
//   a registered, masked interrupt request.
//
//   Optional feature: define RGGEN_W01C_EVENT_OVERFLOW_EN to build sticky
//   per-bit overflow flags and the o_overflow port.
//
//   Parameters:
//     CLEAR_VALUE   : 2'b00 write-0-clear, 2'b01 write-1-clear,
//                     other = any write clears every bit.
//     WRITE_ONLY    : 1 forces read_data to zero.
//     WIDTH         : number of event bits.
//     INITIAL_VALUE : status value loaded by reset.
//     EDGE_MODE     : per bit, 1 = rising-edge capture, 0 = level capture.
//   Ports:
//     i_clk            : clock.
//     i_rst_n          : synchronous active-low reset.
//     bit_field_if     : register access (valid/write_data/write_mask in,
//                        read_data/value out).
//     i_set            : hardware event inputs.
//     i_mask           : per-bit read/interrupt enable (1 = enabled).
//     o_value          : status & i_mask.
//     o_value_unmasked : raw status.
//     o_irq            : registered OR of the masked status.
//     o_overflow       : sticky overflow flags (only with the macro).
module rggen_bit_field_w01c_event #(
  parameter logic [1:0]       CLEAR_VALUE   = 2'b00,
  parameter bit               WRITE_ONLY    = 1'b0,
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter logic [WIDTH-1:0] EDGE_MODE     = '0
)(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  rggen_bit_field_if.bit_field  bit_field_if,
  input  logic [WIDTH-1:0]      i_set,
  input  logic [WIDTH-1:0]      i_mask,
  output logic [WIDTH-1:0]      o_value,
  output logic [WIDTH-1:0]      o_value_unmasked,
  output logic                  o_irq
`ifdef RGGEN_W01C_EVENT_OVERFLOW_EN
  ,
  output logic [WIDTH-1:0]      o_overflow
`endif
);

  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] set_q;
  logic [WIDTH-1:0] set_ev;
  logic [WIDTH-1:0] clear;
  logic             irq_q;

  // Edge-mode bits fire only on a 0->1 transition of i_set; level-mode
  // bits fire every cycle i_set is high.
  always_comb begin
    set_ev = (EDGE_MODE & i_set & ~set_q) | (~EDGE_MODE & i_set);
  end

  always_comb begin
    clear = '0;
    if (bit_field_if.valid && (bit_field_if.write_mask != '0)) begin
      case (CLEAR_VALUE)
        2'b00:   clear = bit_field_if.write_mask & ~bit_field_if.write_data;
        2'b01:   clear = bit_field_if.write_mask &  bit_field_if.write_data;
        default: clear = '1;
      endcase
    end
  end

  // Set is OR'ed in after the clear so an event wins over a clear on the
  // same bit in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      value <= INITIAL_VALUE;
      set_q <= '0;
      irq_q <= 1'b0;
    end else begin
      value <= (value & ~clear) | set_ev;
      set_q <= i_set;
      irq_q <= |(value & i_mask);
    end
  end

`ifdef RGGEN_W01C_EVENT_OVERFLOW_EN
  logic [WIDTH-1:0] overflow;

  // A new event on a bit that is already pending is an overflow; the clear
  // is applied last so it wins over a simultaneous overflow condition.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      overflow <= '0;
    end else begin
      overflow <= (overflow | (set_ev & value)) & ~clear;
    end
  end

  assign o_overflow = overflow;
`endif

  assign o_value_unmasked       = value;
  assign o_value                = value & i_mask;
  assign o_irq                  = irq_q;
  assign bit_field_if.value     = value;
  assign bit_field_if.read_data = WRITE_ONLY ? '0 : (value & i_mask);

endmodule

// File: tb/tb_rggen_bit_field_w01c_event.sv
`timescale 1ns/1ps
module tb_rggen_bit_field_w01c_event;
  localparam int W = 8;
  localparam int N = 3;

  // Instance 0: W0C, INITIAL 8'h81, EDGE 8'h0F
  // Instance 1: W1C, INITIAL 8'h00, EDGE 8'h01
  // Instance 2: clear-all, WRITE_ONLY, INITIAL 8'h3C, EDGE 8'hF0
  localparam logic [N-1:0][1:0] CM   = {2'b10, 2'b01, 2'b00};
  localparam logic [N-1:0]      WO   = 3'b100;
  localparam logic [N-1:0][7:0] INIT = {8'h3C, 8'h00, 8'h81};
  localparam logic [N-1:0][7:0] EDGE = {8'hF0, 8'h01, 8'h0F};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] set_in, mask_in, wd, wm;
  logic       valid;

  logic [7:0] d_unm [N];
  logic [7:0] d_val [N];
  logic [7:0] d_rd  [N];
  logic [7:0] d_bv  [N];
  logic       d_irq [N];
`ifdef RGGEN_W01C_EVENT_OVERFLOW_EN
  logic [7:0] d_ovf [N];
`endif

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      rggen_bit_field_if #(.WIDTH(W)) bif ();
      assign bif.valid      = valid;
      assign bif.write_data = wd;
      assign bif.write_mask = wm;
      assign d_rd[g]        = bif.read_data;
      assign d_bv[g]        = bif.value;

      rggen_bit_field_w01c_event #(
        .CLEAR_VALUE   (CM[g]),
        .WRITE_ONLY    (WO[g]),
        .WIDTH         (W),
        .INITIAL_VALUE (INIT[g]),
        .EDGE_MODE     (EDGE[g])
      ) u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .bit_field_if     (bif.bit_field),
        .i_set            (set_in),
        .i_mask           (mask_in),
        .o_value          (d_val[g]),
        .o_value_unmasked (d_unm[g]),
        .o_irq            (d_irq[g])
`ifdef RGGEN_W01C_EVENT_OVERFLOW_EN
        ,
        .o_overflow       (d_ovf[g])
`endif
      );
    end
  endgenerate

  typedef struct packed {
    logic [N-1:0][7:0] unm;
    logic [N-1:0][7:0] val;
    logic [N-1:0][7:0] rd;
    logic [N-1:0][7:0] ovf;
    logic [N-1:0]      irq;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Reference model state, one entry per instance.
  logic [7:0] m_v   [N];
  logic [7:0] m_ovf [N];
  logic       m_irq [N];
  logic [7:0] m_prev;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got=%h expected=%h", name, idx, $time, act, exp_v);
    end
  endtask

  // Drive one cycle of stimulus and queue what every instance must show
  // after the coming rising edge.
  task automatic cycle(input logic r, input logic [7:0] s, input logic [7:0] m,
                       input logic v, input logic [7:0] d, input logic [7:0] k);
    exp_t e;
    rst_n   = r;
    set_in  = s;
    mask_in = m;
    valid   = v;
    wd      = d;
    wm      = k;
    for (int i = 0; i < N; i++) begin
      if (!r) begin
        m_v[i]   = INIT[i];
        m_ovf[i] = 8'h00;
        m_irq[i] = 1'b0;
      end else begin
        logic [7:0] nv, no;
        m_irq[i] = ((m_v[i] & m) != 8'h00);
        for (int n = 0; n < W; n++) begin
          logic ev, clr;
          if (EDGE[i][n]) ev = s[n] && !m_prev[n];
          else            ev = s[n];
          if (!v || k == 8'h00)  clr = 1'b0;
          else if (CM[i] == 2'b00) clr = k[n] && !d[n];
          else if (CM[i] == 2'b01) clr = k[n] && d[n];
          else                     clr = 1'b1;
          nv[n] = ev ? 1'b1 : (clr ? 1'b0 : m_v[i][n]);
          no[n] = clr ? 1'b0 : (m_ovf[i][n] || (ev && m_v[i][n]));
        end
        m_v[i]   = nv;
        m_ovf[i] = no;
      end
      e.unm[i] = m_v[i];
      e.val[i] = m_v[i] & m;
      e.rd[i]  = WO[i] ? 8'h00 : (m_v[i] & m);
      e.ovf[i] = m_ovf[i];
      e.irq[i] = m_irq[i];
    end
    m_prev = r ? s : 8'h00;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every edge the DUTs present a new state; compare it with the
  // oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int i = 0; i < N; i++) begin
          chk("value_unmasked", i, d_unm[i], e.unm[i]);
          chk("value", i, d_val[i], e.val[i]);
          chk("read_data", i, d_rd[i], e.rd[i]);
          chk("if_value", i, d_bv[i], e.unm[i]);
          chk("irq", i, {7'b0, d_irq[i]}, {7'b0, e.irq[i]});
`ifdef RGGEN_W01C_EVENT_OVERFLOW_EN
          chk("overflow", i, d_ovf[i], e.ovf[i]);
`endif
        end
      end
    end
  end

  initial begin
    m_prev = 8'h00;
    for (int i = 0; i < N; i++) begin
      m_v[i] = 8'h00; m_ovf[i] = 8'h00; m_irq[i] = 1'b0;
    end
    // Reset, including an access that must be discarded.
    cycle(1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'hFF);
    cycle(1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    // Release; irq follows one edge later.
    cycle(1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    // Build 8'hF0 then W1C 8'h30, then mask down to 8'h0F.
    cycle(1'b1, 8'hF0, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h00, 8'hFF, 1'b1, 8'h30, 8'hFF);
    cycle(1'b1, 8'h00, 8'h0F, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h00, 8'h0F, 1'b0, 8'h00, 8'h00);
    // Clear everything, then edge vs level with i_set held at 8'h03.
    cycle(1'b1, 8'h00, 8'hFF, 1'b1, 8'hFF, 8'hFF);
    cycle(1'b1, 8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF);
    cycle(1'b1, 8'h03, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h03, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h03, 8'hFF, 1'b1, 8'h03, 8'h03);
    cycle(1'b1, 8'h03, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h03, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h02, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h03, 8'hFF, 1'b0, 8'h00, 8'h00);
    // Set/clear collision on bit 2.
    cycle(1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h04, 8'hFF, 1'b1, 8'h00, 8'h04);
    cycle(1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    // Bit 3 overflow, then clear it with a write of 8'h08.
    cycle(1'b1, 8'h08, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h08, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h00, 8'hFF, 1'b1, 8'h08, 8'h08);
    cycle(1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    // Clear-all with a narrow mask, then a valid access with zero mask.
    cycle(1'b1, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h01);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00);
    cycle(1'b1, 8'h00, 8'hFF, 1'b1, 8'hFF, 8'h00);
    // Randomised traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      logic       r, v;
      logic [7:0] s, m, d, k;
      r = ($urandom_range(0, 39) != 0);
      s = 8'($urandom) & 8'($urandom);
      m = 8'($urandom);
      v = ($urandom_range(0, 2) == 0);
      d = 8'($urandom);
      k = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cycle(r, s, m, v, d, k);
    end
    stim_done = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
